// File: rtl/axis_msg_splitter.sv
// AXI-Stream frame splitter: length-prefixed messages out, one per handshake.
// Parses count/length/payload fields across beats and reports coded frame errors.
module axis_msg_splitter #(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic                       s_tlast,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [15:0]                msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic                       s_terror,
  output logic [3:0]                 err_code
);
  localparam int CW = $clog2(DATA_BYTES) + 1;
  localparam int MW = 8 * MAX_MSG_BYTES;
  localparam logic [15:0] MIN_L = 16'(MIN_MSG_BYTES);
  localparam logic [15:0] MAX_L = 16'(MAX_MSG_BYTES);

  typedef enum logic [1:0] {S_CNT, S_LEN, S_PAY, S_DROP} state_e;

  state_e                  state_q, state_d;
  logic                    fcnt_q, fcnt_d;
  logic [7:0]              lo_q, lo_d;
  logic [15:0]             num_q, num_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             pcnt_q, pcnt_d;
  logic [15:0]             msgs_q, msgs_d;
  logic [3:0]              err_q, err_d;
  logic [MW-1:0]           asm_q, asm_d;
  logic [8*DATA_BYTES-1:0] beat_q, beat_d;
  logic                    full_q, full_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           nb_q, nb_d;
  logic [CW-1:0]           cur_q, cur_d;
  logic                    ovld_q, ovld_d;
  logic [15:0]             olen_q, olen_d;
  logic [MW-1:0]           odat_q, odat_d;
  logic                    terr_q, terr_d;
  logic [3:0]              ecode_q, ecode_d;

  state_e        st;
  logic          fc, emit, stop, stall, done, frame_end, keep_ok, accept;
  logic [7:0]    lo, b;
  logic [15:0]   num, len, pc, msgs;
  logic [3:0]    err, fe_code;
  logic [MW-1:0] asmb;
  logic [CW-1:0] cur;

  always_comb begin
    st = state_q; fc = fcnt_q; lo = lo_q; num = num_q;
    len = len_q; pc = pcnt_q; msgs = msgs_q; err = err_q;
    asmb = asm_q; cur = cur_q; emit = 1'b0; stop = 1'b0; b = '0;
    // Walk the held beat from the cursor; stop after one completed message
    if (full_q) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (!stop && CW'(i) >= cur_q && CW'(i) < nb_q) begin
          b = beat_q[8*i +: 8];
          cur = CW'(i + 1);
          unique case (st)
            S_CNT: begin
              if (!fc) begin
                lo = b; fc = 1'b1;
              end else begin
                fc = 1'b0; num = {b, lo};
                st = (num == 16'd0) ? S_DROP : S_LEN;
              end
            end
            S_LEN: begin
              if (!fc) begin
                lo = b; fc = 1'b1;
              end else begin
                fc = 1'b0; len = {b, lo};
                asmb = '0; pc = 16'd0;
                if (len < MIN_L || len > MAX_L) begin
                  err[0] = 1'b1; st = S_DROP;
                end else begin
                  st = S_PAY;
                end
              end
            end
            S_PAY: begin
              for (int j = 0; j < MAX_MSG_BYTES; j++)
                if (pc == 16'(j)) asmb[8*j +: 8] = b;
              pc = pc + 16'd1;
              if (pc == len) begin
                emit = 1'b1; stop = 1'b1;
                msgs = msgs + 16'd1;
                st = (msgs == num) ? S_DROP : S_LEN;
              end
            end
            S_DROP: begin
              if (b != 8'd0 && !err[0]) err[3] = 1'b1;
            end
          endcase
        end
      end
    end

    stall = emit && ovld_q && !msg_ready;
    done = full_q && !stall && (cur >= nb_q);
    frame_end = done && last_q;
    fe_code = {err[3], st != S_DROP,
               (st == S_PAY) || ((st == S_CNT || st == S_LEN) && fc),
               err[0]};
    s_tready = !rst && (!full_q || done);
    accept = s_tvalid && s_tready;
    keep_ok = ((s_tkeep & (s_tkeep + DATA_BYTES'(1))) == '0);

    state_d = state_q; fcnt_d = fcnt_q; lo_d = lo_q; num_d = num_q;
    len_d = len_q; pcnt_d = pcnt_q; msgs_d = msgs_q; err_d = err_q;
    asm_d = asm_q; beat_d = beat_q; full_d = full_q; last_d = last_q;
    nb_d = nb_q; cur_d = cur_q;
    if (full_q && !stall) begin
      state_d = st; fcnt_d = fc; lo_d = lo; num_d = num;
      len_d = len; pcnt_d = pc; msgs_d = msgs; err_d = err;
      asm_d = asmb; cur_d = cur;
      if (done) full_d = 1'b0;
      if (frame_end) begin
        state_d = S_CNT; fcnt_d = 1'b0;
        msgs_d = 16'd0; err_d = 4'd0;
      end
    end
    terr_d = frame_end && (fe_code != 4'd0);
    ecode_d = terr_d ? fe_code : 4'd0;
    if (accept) begin
      beat_d = s_tdata; full_d = 1'b1;
      cur_d = '0; last_d = s_tlast;
      if (!s_tlast) nb_d = CW'(DATA_BYTES);
      else if (keep_ok) nb_d = CW'($countones(s_tkeep));
      else nb_d = '0;
      if (s_tlast && !keep_ok) err_d[3] = 1'b1;
    end

    ovld_d = ovld_q && !msg_ready;
    olen_d = olen_q; odat_d = odat_q;
    if (emit && !stall) begin
      ovld_d = 1'b1; olen_d = len; odat_d = asmb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CNT; fcnt_q <= 1'b0; lo_q <= '0;
      num_q <= '0; len_q <= '0; pcnt_q <= '0;
      msgs_q <= '0; err_q <= '0; asm_q <= '0;
      beat_q <= '0; full_q <= 1'b0; last_q <= 1'b0;
      nb_q <= '0; cur_q <= '0;
      ovld_q <= 1'b0; olen_q <= '0; odat_q <= '0;
      terr_q <= 1'b0; ecode_q <= '0;
    end else begin
      state_q <= state_d; fcnt_q <= fcnt_d; lo_q <= lo_d;
      num_q <= num_d; len_q <= len_d; pcnt_q <= pcnt_d;
      msgs_q <= msgs_d; err_q <= err_d; asm_q <= asm_d;
      beat_q <= beat_d; full_q <= full_d; last_q <= last_d;
      nb_q <= nb_d; cur_q <= cur_d;
      ovld_q <= ovld_d; olen_q <= olen_d; odat_q <= odat_d;
      terr_q <= terr_d; ecode_q <= ecode_d;
    end
  end

  assign msg_valid  = ovld_q;
  assign msg_length = olen_q;
  assign msg_data   = odat_q;
  assign s_terror   = terr_q;
  assign err_code   = ecode_q;
endmodule

// File: tb/tb_axis_msg_splitter.sv
// Bench for axis_msg_splitter: directed frames plus random frames
// checked against a byte-offset reference parser.
module tb_axis_msg_splitter;
  localparam int DB = 8;
  localparam int MAXB = 32;
  localparam int MINB = 1;

  typedef logic [7:0] u8;
  typedef struct {
    logic [15:0]       len;
    logic [8*MAXB-1:0] data;
  } msg_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [8*DB-1:0] s_tdata = '0;
  logic [DB-1:0]   s_tkeep = '0;
  logic            s_tlast = 1'b0;
  logic            msg_valid;
  logic            msg_ready = 1'b1;
  logic [15:0]     msg_length;
  logic [8*MAXB-1:0] msg_data;
  logic            s_terror;
  logic [3:0]      err_code;

  msg_t got_q[$], exp_q[$];
  logic [3:0] gerr_q[$], eerr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit rdy_rand = 0;
  logic rdy_val = 1'b1;
  bit gap_en = 0;

  always #5 clk = ~clk;

  axis_msg_splitter #(
    .DATA_BYTES(DB), .MAX_MSG_BYTES(MAXB), .MIN_MSG_BYTES(MINB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_length(msg_length), .msg_data(msg_data),
    .s_terror(s_terror), .err_code(err_code)
  );

  initial forever begin
    @(posedge clk); #1;
    msg_ready = rdy_rand ? 1'($urandom % 2) : rdy_val;
  end

  initial begin : mon
    msg_t m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (msg_valid && msg_ready) begin
          m.len = msg_length; m.data = msg_data;
          got_q.push_back(m);
        end
        if (s_terror) gerr_q.push_back(err_code);
      end
    end
  end

  task automatic clear_q();
    got_q.delete(); exp_q.delete();
    gerr_q.delete(); eerr_q.delete();
  endtask

  task automatic drain();
    rdy_rand = 0; rdy_val = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send_frame(input u8 fr[$], input bit last, output int lows);
    int nb;
    nb = (fr.size() + DB - 1) / DB;
    lows = 0;
    @(posedge clk); #1;
    for (int bi = 0; bi < nb; bi++) begin
      logic [8*DB-1:0] d;
      logic [DB-1:0] k;
      bit acc;
      d = '0; k = '0;
      for (int j = 0; j < DB; j++)
        if (bi*DB + j < fr.size()) begin
          d[8*j +: 8] = fr[bi*DB + j]; k[j] = 1'b1;
        end
      if (gap_en && ($urandom % 3 == 0)) begin
        s_tvalid = 1'b0; @(posedge clk); #1;
      end
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k;
      s_tlast = last && (bi == nb - 1);
      acc = 0;
      for (int t = 0; t < 500 && !acc; t++) begin
        @(negedge clk);
        if (s_tready) acc = 1; else lows++;
        @(posedge clk); #1;
      end
      if (!acc) begin
        n_checks++;
        $display("FAIL beat_accept: s_tready never high, need 1");
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Reference parser working on byte offsets within the whole frame
  task automatic model_frame(input u8 fr[$]);
    int n, pos, cnt, l;
    logic [3:0] e;
    bit fin;
    msg_t m;
    n = fr.size(); e = '0; fin = 0; pos = 2; cnt = 0;
    if (n < 2) begin
      e[2] = 1'b1; e[1] = (n == 1); fin = 1;
    end else cnt = int'(fr[0]) + 256 * int'(fr[1]);
    for (int k = 0; k < cnt && !fin; k++) begin
      if (pos + 2 > n) begin
        e[2] = 1'b1; e[1] = (pos < n); fin = 1;
      end else begin
        l = int'(fr[pos]) + 256 * int'(fr[pos+1]);
        pos += 2;
        if (l < MINB || l > MAXB) begin
          e[0] = 1'b1; fin = 1;
        end else if (pos + l > n) begin
          e[1] = 1'b1; e[2] = 1'b1; fin = 1;
        end else begin
          m.len = 16'(l); m.data = '0;
          for (int j = 0; j < l; j++) m.data[8*j +: 8] = fr[pos+j];
          exp_q.push_back(m);
          pos += l;
        end
      end
    end
    if (!fin)
      for (int p = pos; p < n; p++) if (fr[p] != 8'd0) e[3] = 1'b1;
    if (e != 4'd0) eerr_q.push_back(e);
  endtask

  task automatic gen_frame(output u8 fr[$]);
    int n, l, plen, cut;
    fr.delete();
    n = $urandom % 4;
    fr.push_back(u8'(n)); fr.push_back(8'h00);
    for (int k = 0; k < n; k++) begin
      if ($urandom % 10 == 0) begin
        case ($urandom % 3)
          0: l = 0;
          1: l = MAXB + 1;
          default: l = 16'hFFFF;
        endcase
        plen = 3;
      end else begin
        l = 1 + $urandom % MAXB; plen = l;
      end
      fr.push_back(u8'(l)); fr.push_back(u8'(l >> 8));
      for (int j = 0; j < plen; j++) fr.push_back(u8'($urandom));
    end
    if ($urandom % 3 == 0)
      for (int j = 0; j < 1 + $urandom % 4; j++)
        fr.push_back(($urandom % 4 == 0) ? 8'h00 : u8'($urandom));
    if ($urandom % 4 == 0) begin
      cut = 1 + $urandom % (fr.size() - 1);
      while (fr.size() > cut) void'(fr.pop_back());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({s_tready, msg_valid, s_terror, err_code, msg_length, msg_data} !== '0)
      $display("FAIL reset_outputs: tready=%b valid=%b terr=%b code=%h len=%h",
               s_tready, msg_valid, s_terror, err_code, msg_length);
    else n_pass++;
    rst = 1'b0; #1;
    n_checks++;
    if (s_tready !== 1'b1)
      $display("FAIL reset_tready: got %b need 1", s_tready);
    else n_pass++;
  endtask

  task automatic test_single();
    u8 fr[$]; int lows;
    clear_q();
    fr = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr, 1, lows);
    drain();
    n_checks++;
    if (got_q.size() != 1) $display("FAIL single_count: got %0d need 1", got_q.size());
    else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++;
      if (got_q[0].len !== 16'd4 || got_q[0].data !== 256'h44332211)
        $display("FAIL single_msg: len %0d data %h need 4 44332211",
                 got_q[0].len, got_q[0].data);
      else n_pass++;
    end
    n_checks++;
    if (gerr_q.size() != 0) $display("FAIL single_err: got %0d pulses need 0", gerr_q.size());
    else n_pass++;
  endtask

  task automatic test_two_in_beat();
    u8 fr[$]; int lows;
    logic [7:0] expb [3];
    clear_q();
    expb = '{8'hA1, 8'hB2, 8'hC3};
    fr = '{8'h03, 8'h00, 8'h01, 8'h00, 8'hA1, 8'h01, 8'h00, 8'hB2,
           8'h01, 8'h00, 8'hC3};
    send_frame(fr, 1, lows);
    drain();
    n_checks++;
    if (lows != 1) $display("FAIL two_tready_low: got %0d cycles need 1", lows);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 3) $display("FAIL two_count: got %0d need 3", got_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].len !== 16'd1 || got_q[i].data !== 256'(expb[i]))
        $display("FAIL two_msg%0d: len %0d data %h need 1 %h",
                 i, got_q[i].len, got_q[i].data, expb[i]);
      else n_pass++;
    end
    n_checks++;
    if (gerr_q.size() != 0) $display("FAIL two_err: got %0d pulses need 0", gerr_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    u8 fr[$]; int lows;
    logic [15:0] hl; logic [8*MAXB-1:0] hd;
    clear_q();
    rdy_val = 1'b0;
    fr = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h04, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(fr, 1, lows);
    @(negedge clk);
    n_checks++;
    if (msg_valid !== 1'b1 || s_tready !== 1'b0)
      $display("FAIL bp_stall: valid %b tready %b need 1 0", msg_valid, s_tready);
    else n_pass++;
    hl = msg_length; hd = msg_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (msg_valid !== 1'b1 || msg_length !== hl || msg_data !== hd)
        $display("FAIL bp_hold%0d: valid %b len %0d need 1 %0d", c, msg_valid, msg_length, hl);
      else n_pass++;
    end
    drain();
    n_checks++;
    if (got_q.size() != 2) $display("FAIL bp_count: got %0d need 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0].data !== 256'h44332211 || got_q[1].data !== 256'h88776655 ||
          got_q[0].len !== 16'd4 || got_q[1].len !== 16'd4)
        $display("FAIL bp_data: got %h %h need 44332211 88776655",
                 got_q[0].data, got_q[1].data);
      else n_pass++;
    end
  endtask

  task automatic test_len_err();
    u8 fr[$]; int lows;
    clear_q();
    fr = '{8'h02, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h30, 8'h00,
           8'h01, 8'h02, 8'h03};
    send_frame(fr, 1, lows);
    fr = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h77};
    send_frame(fr, 1, lows);
    drain();
    n_checks++;
    if (gerr_q.size() != 1) $display("FAIL len_err_pulses: got %0d need 1", gerr_q.size());
    else n_pass++;
    if (gerr_q.size() > 0) begin
      n_checks++;
      if (gerr_q[0] !== 4'b0001) $display("FAIL len_err_code: got %b need 0001", gerr_q[0]);
      else n_pass++;
    end
    n_checks++;
    if (got_q.size() != 2) $display("FAIL len_err_count: got %0d need 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0].data !== 256'hBBAA || got_q[1].data !== 256'h77 ||
          got_q[0].len !== 16'd2 || got_q[1].len !== 16'd1)
        $display("FAIL len_err_msgs: got %h %h need bbaa 77", got_q[0].data, got_q[1].data);
      else n_pass++;
    end
  endtask

  task automatic test_trunc();
    u8 fr[$]; int lows;
    clear_q();
    fr = '{8'h02, 8'h00, 8'h02, 8'h00, 8'hCC, 8'hDD, 8'h08, 8'h00,
           8'h01, 8'h02, 8'h03};
    send_frame(fr, 1, lows);
    drain();
    n_checks++;
    if (got_q.size() != 1) $display("FAIL trunc_count: got %0d need 1", got_q.size());
    else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++;
      if (got_q[0].data !== 256'hDDCC) $display("FAIL trunc_msg: got %h need ddcc", got_q[0].data);
      else n_pass++;
    end
    n_checks++;
    if (gerr_q.size() != 1 || (gerr_q.size() > 0 && gerr_q[0] !== 4'b0110))
      $display("FAIL trunc_code: pulses %0d code %b need 1 0110",
               gerr_q.size(), gerr_q.size() > 0 ? gerr_q[0] : 4'bx);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    u8 fr[$]; int lows;
    clear_q();
    rdy_val = 1'b0;
    fr = '{8'h02, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h10, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(fr, 0, lows);
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++;
    if ({s_tready, msg_valid, s_terror, err_code, msg_length, msg_data} !== '0)
      $display("FAIL midrst_outputs: tready=%b valid=%b len=%h", s_tready, msg_valid, msg_length);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_val = 1'b1;
    fr = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h5A, 8'hA5};
    send_frame(fr, 1, lows);
    drain();
    n_checks++;
    if (got_q.size() != 1) $display("FAIL midrst_count: got %0d need 1", got_q.size());
    else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++;
      if (got_q[0].len !== 16'd2 || got_q[0].data !== 256'hA55A)
        $display("FAIL midrst_msg: len %0d data %h need 2 a55a", got_q[0].len, got_q[0].data);
      else n_pass++;
    end
    n_checks++;
    if (gerr_q.size() != 0) $display("FAIL midrst_err: got %0d pulses need 0", gerr_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    u8 fr[$]; int lows;
    for (int r = 0; r < 12; r++) begin
      clear_q();
      rdy_rand = 1; gap_en = 1;
      for (int f = 0; f < 3; f++) begin
        gen_frame(fr);
        model_frame(fr);
        send_frame(fr, 1, lows);
      end
      gap_en = 0;
      drain();
      n_checks++;
      if (got_q.size() != exp_q.size())
        $display("FAIL rand%0d_count: got %0d need %0d", r, got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i].len !== exp_q[i].len || got_q[i].data !== exp_q[i].data)
          $display("FAIL rand%0d_msg%0d: len %0d data %h need %0d %h", r, i,
                   got_q[i].len, got_q[i].data, exp_q[i].len, exp_q[i].data);
        else n_pass++;
      end
      n_checks++;
      if (gerr_q.size() != eerr_q.size())
        $display("FAIL rand%0d_errcount: got %0d need %0d", r, gerr_q.size(), eerr_q.size());
      else n_pass++;
      for (int i = 0; i < gerr_q.size() && i < eerr_q.size(); i++) begin
        n_checks++;
        if (gerr_q[i] !== eerr_q[i])
          $display("FAIL rand%0d_err%0d: got %b need %b", r, i, gerr_q[i], eerr_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_in_beat();
    test_backpressure();
    test_len_err();
    test_trunc();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
